// File: rtl/hazard_scheduler.sv
// Operand hazard controller: issues S2 into S3, tracks S3..S6 writers, stalls on load-use, registers bypass selects.
// Optional event counters (stall_count, bypass_count) are built only when HAZARD_COUNTERS_EN is defined.
module hazard_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        s2_valid,
  input  logic [4:0]  s2_rs1,
  input  logic [4:0]  s2_rs2,
  input  logic        s2_use_rs1,
  input  logic        s2_use_rs2,
  input  logic [4:0]  s2_rd,
  input  logic        s2_writes_rd,
  input  logic        s2_is_load,
  input  logic        ext_stall,
  input  logic        do_flush,
  output logic        fe_stall,
  output logic        s3_valid,
  output logic [1:0]  bypass,
  output logic [1:0]  rs1_src,
  output logic [1:0]  rs2_src
`ifdef HAZARD_COUNTERS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] bypass_count
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  // Index 0 is S3, index 3 is S6.
  sb_entry_t  r_sb [4];
  logic       r_s3_valid;
  logic [1:0] r_bypass;
  logic [1:0] r_rs1_src;
  logic [1:0] r_rs2_src;

  logic       w_hazard;
  logic       w_lu_stall;
  logic       w_issue;
  logic [1:0] w_byp;
  logic [1:0] w_src1;
  logic [1:0] w_src2;
  sb_entry_t  w_s2_entry;

  function automatic logic f_match(sb_entry_t e, logic [4:0] idx, logic use_op);
    return e.valid && e.wr && (e.rd == idx) && (idx != 5'd0) && use_op;
  endfunction

  // A load in S3 or S4 has no result yet for a consumer issuing now.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r_sb[i].ld && (f_match(r_sb[i], s2_rs1, s2_use_rs1) ||
                         f_match(r_sb[i], s2_rs2, s2_use_rs2)))
        w_hazard = 1'b1;
    end
  end

  assign w_lu_stall = s2_valid && w_hazard && !do_flush;
  assign w_issue    = s2_valid && !w_hazard && !do_flush;
  assign fe_stall   = w_lu_stall || ext_stall;

  // Walk oldest to youngest so the youngest match overwrites; entry i lands in S(4+i) after the advance.
  always_comb begin
    w_byp  = 2'b00;
    w_src1 = 2'b00;
    w_src2 = 2'b00;
    for (int i = 2; i >= 0; i--) begin
      if (f_match(r_sb[i], s2_rs1, s2_use_rs1)) begin
        w_byp[0] = 1'b1;
        w_src1   = 2'(i);
      end
      if (f_match(r_sb[i], s2_rs2, s2_use_rs2)) begin
        w_byp[1] = 1'b1;
        w_src2   = 2'(i);
      end
    end
  end

  always_comb begin
    w_s2_entry       = '0;
    w_s2_entry.valid = w_issue;
    w_s2_entry.rd    = s2_rd;
    w_s2_entry.wr    = s2_writes_rd;
    w_s2_entry.ld    = s2_is_load;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_sb[i] <= '0;
      r_s3_valid <= 1'b0;
      r_bypass   <= 2'b00;
      r_rs1_src  <= 2'b00;
      r_rs2_src  <= 2'b00;
    end else if (!ext_stall) begin
      r_sb[0] <= w_issue ? w_s2_entry : '0;
      for (int i = 1; i < 4; i++) r_sb[i] <= r_sb[i-1];
      r_s3_valid <= w_issue;
      r_bypass   <= w_issue ? w_byp  : 2'b00;
      r_rs1_src  <= w_issue ? w_src1 : 2'b00;
      r_rs2_src  <= w_issue ? w_src2 : 2'b00;
    end
  end

  assign s3_valid = r_s3_valid;
  assign bypass   = r_bypass;
  assign rs1_src  = r_rs1_src;
  assign rs2_src  = r_rs2_src;

`ifdef HAZARD_COUNTERS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_bypass_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count  <= 32'd0;
      r_bypass_count <= 32'd0;
    end else if (!ext_stall) begin
      if (w_lu_stall) r_stall_count <= r_stall_count + 32'd1;
      if (w_issue && (w_byp != 2'b00)) r_bypass_count <= r_bypass_count + 32'd1;
    end
  end

  assign stall_count  = r_stall_count;
  assign bypass_count = r_bypass_count;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized + directed bench for hazard_scheduler: reference model over an issue-history queue, scoreboard monitor on S3 outputs.
module tb_hazard_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s2_valid = 1'b0;
  logic [4:0] s2_rs1 = '0, s2_rs2 = '0, s2_rd = '0;
  logic       s2_use_rs1 = 1'b0, s2_use_rs2 = 1'b0;
  logic       s2_writes_rd = 1'b0, s2_is_load = 1'b0;
  logic       ext_stall = 1'b0, do_flush = 1'b0;
  logic       fe_stall, s3_valid;
  logic [1:0] bypass, rs1_src, rs2_src;
`ifdef HAZARD_COUNTERS_EN
  logic [31:0] stall_count, bypass_count;
`endif

  hazard_scheduler dut (
    .clock(clock), .reset(reset), .s2_valid(s2_valid),
    .s2_rs1(s2_rs1), .s2_rs2(s2_rs2), .s2_use_rs1(s2_use_rs1), .s2_use_rs2(s2_use_rs2),
    .s2_rd(s2_rd), .s2_writes_rd(s2_writes_rd), .s2_is_load(s2_is_load),
    .ext_stall(ext_stall), .do_flush(do_flush),
    .fe_stall(fe_stall), .s3_valid(s3_valid), .bypass(bypass),
    .rs1_src(rs1_src), .rs2_src(rs2_src)
`ifdef HAZARD_COUNTERS_EN
    , .stall_count(stall_count), .bypass_count(bypass_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    bit       v;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } s2_t;

  typedef struct packed {
    bit       v;
    bit [1:0] byp;
    bit [1:0] s1;
    bit [1:0] s2;
  } exp_t;

  s2_t  hist[$];          // issue history, youngest first: hist[a] is 'a' stages past S3
  exp_t expq[$];
  exp_t last_e = '0;
  int   n_chk = 0, n_fail = 0;
  bit [31:0] m_stall_cnt = 0, m_byp_cnt = 0;
  bit   mon_en = 1'b0;
  bit   dut_fs;
  bit   m_lu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input int a, input bit [4:0] idx, input bit u);
    if (a >= hist.size()) return 1'b0;
    return hist[a].v && hist[a].wr && (hist[a].rd == idx) && (idx != 0) && u;
  endfunction

  function automatic bit m_hazard(input s2_t s);
    for (int a = 0; a < 2; a++)
      if (a < hist.size() && hist[a].ld && (writes(a, s.rs1, s.u1) || writes(a, s.rs2, s.u2)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_src(input bit [4:0] idx, input bit u, output bit hit, output bit [1:0] src);
    hit = 1'b0;
    src = 2'b00;
    for (int a = 0; a < 3; a++)
      if (!hit && writes(a, idx, u)) begin
        hit = 1'b1;
        src = 2'(a);
      end
  endfunction

  function automatic s2_t mk(input bit [4:0] rd, input bit wr, input bit ld,
                             input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2);
    s2_t s;
    s.v = 1'b1; s.rd = rd; s.wr = wr; s.ld = ld;
    s.rs1 = r1; s.u1 = u1; s.rs2 = r2; s.u2 = u2;
    return s;
  endfunction

  task automatic cycle(input s2_t s, input bit est, input bit fl, input bit rst_mid);
    bit   hz, issue, h1, h2;
    bit [1:0] sr1, sr2;
    exp_t e;
    s2_t  ni;
    @(negedge clock);
    s2_valid = s.v; s2_rs1 = s.rs1; s2_rs2 = s.rs2; s2_use_rs1 = s.u1; s2_use_rs2 = s.u2;
    s2_rd = s.rd; s2_writes_rd = s.wr; s2_is_load = s.ld;
    ext_stall = est; do_flush = fl;
    if (rst_mid) begin
      #1 reset = 1'b0;
      #1;
      chk("rst_mid_s3_valid", s3_valid, 0);
      chk("rst_mid_bypass", bypass, 0);
      chk("rst_mid_rs1_src", rs1_src, 0);
      chk("rst_mid_rs2_src", rs2_src, 0);
      chk("rst_mid_fe_stall", fe_stall, 32'(est));
`ifdef HAZARD_COUNTERS_EN
      chk("rst_mid_stall_count", stall_count, 0);
      chk("rst_mid_bypass_count", bypass_count, 0);
`endif
      hist.delete();
      expq.delete();
      last_e = '0;
      m_stall_cnt = 0;
      m_byp_cnt = 0;
      reset = 1'b1;
    end
    #1;
`ifdef HAZARD_COUNTERS_EN
    chk("stall_count", stall_count, m_stall_cnt);
    chk("bypass_count", bypass_count, m_byp_cnt);
`endif
    hz = m_hazard(s);
    m_lu = s.v && hz && !fl;
    chk("fe_stall", fe_stall, 32'(m_lu || est));
    dut_fs = fe_stall;
    if (!est) begin
      issue = s.v && !hz && !fl;
      e = '0;
      e.v = issue;
      h1 = 0; h2 = 0;
      if (issue) begin
        m_src(s.rs1, s.u1, h1, sr1);
        m_src(s.rs2, s.u2, h2, sr2);
        e.byp = {h2, h1};
        e.s1 = h1 ? sr1 : 2'b00;
        e.s2 = h2 ? sr2 : 2'b00;
      end
      expq.push_back(e);
      if (m_lu) m_stall_cnt++;
      if (issue && (h1 || h2)) m_byp_cnt++;
      ni = s;
      ni.v = issue;
      hist.push_front(ni);
      if (hist.size() > 4) void'(hist.pop_back());
    end
  endtask

  // Scoreboard monitor: each advancing edge presents one new S3 slot; frozen edges must hold outputs.
  initial begin
    bit   adv;
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clock);
      adv = !ext_stall && reset;
      #1;
      if (adv) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL expq_underflow: output presented with no expectation at %0t", $time);
        end else begin
          e = expq.pop_front();
          last_e = e;
        end
      end
      if (reset) begin
        chk("s3_valid", s3_valid, 32'(last_e.v));
        chk("bypass", bypass, 32'(last_e.byp));
        chk("rs1_src", rs1_src, 32'(last_e.s1));
        chk("rs2_src", rs2_src, 32'(last_e.s2));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    s2_t nop, cons, s;
    int  cnt;
    bit  est, fl;
    nop = '0;

    repeat (2) @(negedge clock);
    chk("reset_s3_valid", s3_valid, 0);
    chk("reset_bypass", bypass, 0);
    chk("reset_rs1_src", rs1_src, 0);
    chk("reset_rs2_src", rs2_src, 0);
    chk("reset_fe_stall", fe_stall, 0);
`ifdef HAZARD_COUNTERS_EN
    chk("reset_stall_count", stall_count, 0);
    chk("reset_bypass_count", bypass_count, 0);
`endif
    ext_stall = 1'b1;
    #1 chk("reset_fe_stall_ext", fe_stall, 1);
    ext_stall = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #2 mon_en = 1'b1;

    // ALU chain: add x5 ; add x6,x5,x5
    cycle(mk(5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 0, 0, 0);
    cycle(mk(5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 0, 0, 0);
    chk("alu_chain_no_stall", fe_stall, 0);
    repeat (4) cycle(nop, 0, 0, 0);

    // Load-use: lw x7 ; add x8,x7,x0
    cycle(mk(5'd7, 1, 1, 5'd2, 1, 5'd0, 0), 0, 0, 0);
    cons = mk(5'd8, 1, 0, 5'd7, 1, 5'd0, 1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(cons, 0, 0, 0);
      if (dut_fs) cnt++;
      else break;
    end
    chk("loaduse_stall_cycles", cnt, 2);
    repeat (4) cycle(nop, 0, 0, 0);

    // Priority: x9 writers that land in S6 and S4, then a reader; x0 writer then x0 reader
    cycle(mk(5'd9, 1, 0, 5'd1, 1, 5'd1, 1), 0, 0, 0);
    cycle(mk(5'd10, 1, 0, 5'd1, 1, 5'd1, 1), 0, 0, 0);
    cycle(mk(5'd9, 1, 0, 5'd2, 1, 5'd2, 1), 0, 0, 0);
    cycle(mk(5'd11, 1, 0, 5'd9, 1, 5'd3, 1), 0, 0, 0);
    cycle(mk(5'd0, 1, 0, 5'd1, 1, 5'd1, 1), 0, 0, 0);
    cycle(mk(5'd12, 1, 0, 5'd0, 1, 5'd0, 1), 0, 0, 0);
    repeat (4) cycle(nop, 0, 0, 0);

    // Flush concurrent with load-use hazard
    cycle(mk(5'd7, 1, 1, 5'd2, 1, 5'd0, 0), 0, 0, 0);
    cycle(cons, 0, 1, 0);
    chk("flush_no_stall", dut_fs, 0);
    repeat (4) cycle(nop, 0, 0, 0);

    // Freeze mid load-use
    cycle(mk(5'd7, 1, 1, 5'd2, 1, 5'd0, 0), 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      est = (k >= 1 && k <= 3);
      cycle(cons, est, 0, 0);
      if (!est && dut_fs) cnt++;
      if (!est && !dut_fs) break;
    end
    chk("freeze_hazard_bubbles", cnt, 2);
    repeat (4) cycle(nop, 0, 0, 0);

    // Reset during a load-use stall
    cycle(mk(5'd7, 1, 1, 5'd2, 1, 5'd0, 0), 0, 0, 0);
    cycle(cons, 0, 0, 0);
    cycle(cons, 0, 0, 1);
    repeat (4) cycle(nop, 0, 0, 0);

    // Random traffic; S2 holds its instruction while the front end is stalled
    s = nop;
    est = 0;
    for (int k = 0; k < 600; k++) begin
      if (!(dut_fs && (est || m_lu))) begin
        s.v   = ($urandom_range(0, 3) != 0);
        s.rd  = 5'($urandom_range(0, 7));
        s.wr  = ($urandom_range(0, 4) != 0);
        s.ld  = ($urandom_range(0, 2) == 0);
        s.rs1 = 5'($urandom_range(0, 7));
        s.rs2 = 5'($urandom_range(0, 7));
        s.u1  = ($urandom_range(0, 3) != 0);
        s.u2  = ($urandom_range(0, 3) != 0);
      end
      est = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      cycle(s, est, fl, 0);
    end
    cycle(nop, 0, 0, 0);
    cycle(nop, 0, 0, 0);
    @(posedge clock);
    #2;
    chk("expq_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Operand hazard controller for the execute stage. Tracks destination registers of in-flight instructions in S3–S6, issues decoded instructions from S2 into S3, and produces registered bypass selects for the execute datapath. Inserts load-use bubbles by stalling the front end, and squashes younger work on a taken-branch flush. Sits between the S2 decode registers and the S3 execute block; drives its `stall`, `valid` and `bypass` inputs.

## Interface
- No parameters; register index width fixed at 5, pipeline depth tracked fixed at S3–S6.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `s2_valid` in 1: S2 holds a real instruction.
- `s2_rs1`, `s2_rs2` in 5: source register indices.
- `s2_use_rs1`, `s2_use_rs2` in 1: instruction reads that operand.
- `s2_rd` in 5: destination index.
- `s2_writes_rd` in 1: instruction writes `s2_rd`.
- `s2_is_load` in 1: instruction is a load; result exists only in S6.
- `ext_stall` in 1: memory backpressure; freezes S2–S6.
- `do_flush` in 1: taken jump/branch resolved in S3 this cycle.
- `fe_stall` out 1: hold S1/S1a/S2.
- `s3_valid` out 1: S3 instruction is real.
- `bypass` out 2: bit 0 RS1, bit 1 RS2; operand taken from bypass network.
- `rs1_src`, `rs2_src` out 2: bypass source: 00 S4 ALU result, 01 S5 result, 10 S6 writeback, 11 unused.
- `stall_count`, `bypass_count` out 32: present only with `HAZARD_COUNTERS_EN`.

## Operation
- Scoreboard: 4-entry shift register S3..S6, each entry {valid, rd, writes_rd, is_load}. Advances one slot per cycle unless `ext_stall`.
- Match: entry valid, writes_rd, rd == operand index, index != 0, operand used. x0 never matches.
- Load-use (combinational, from S2 inputs and scoreboard): match against load in S3 -> needs 2 bubbles; against load in S4 -> 1 bubble; load in S5 or later -> no bubble (served from S6).
- `fe_stall` = `s2_valid` & load-use hazard & !`do_flush`, or `ext_stall`.
- Issue: when not frozen, S3 entry <= S2 instruction if `s2_valid` & !hazard & !`do_flush`; else bubble (valid 0).
- Bypass select, computed at issue against the post-advance positions (current S3 -> S4, S4 -> S5, S5 -> S6); youngest match wins: S4 > S5 > S6. No match -> `bypass` bit 0, register file value used.
- `bypass`, `rsX_src`, `s3_valid` are registered and align with the instruction in S3.
- `do_flush` kills S2 issue only; S3 instruction (the branch) proceeds; older entries unaffected.
- Priority: `reset` > `ext_stall` > `do_flush` > load-use hazard.

## Timing
- Reset: all scoreboard entries invalid; `s3_valid` 0, `bypass` 00, `rs1_src`/`rs2_src` 00, `fe_stall` 0 (unless `ext_stall`), counters 0.
- `fe_stall` combinational, same cycle as S2 inputs; all other outputs one cycle after issue edge.
- `ext_stall` high: all registers hold, outputs unchanged; `fe_stall` 1.
- Load-use: consumer in S2 sees 2 (or 1) stall cycles, then issues with `rsX_src`=10.
- Flush concurrent with hazard: no stall, S3 receives bubble next cycle.
- Reset asserted mid-stall: stall released immediately, scoreboard empty.
- Both operands same register: both bits set, identical sources.

## Configuration
- `HAZARD_COUNTERS_EN` defined: `stall_count` increments each cycle load-use hazard drives `fe_stall` (not `ext_stall`-only cycles); `bypass_count` increments on each issue with any `bypass` bit set; both wrap at 2^32, hold under `ext_stall`, clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- ALU chain: `add x5` then `add x6,x5,x5` back-to-back -> no stall, consumer in S3 with `bypass`=11, both src 00.
- Load-use: `lw x7` then `add x8,x7,x0` -> `fe_stall` 2 cycles, consumer in S3 with `bypass`=01, `rs1_src`=10; `stall_count` +2.
- Priority: writers to x9 in S4 and S6 -> `rs1_src`=00; x0 writer ahead of `use x0` -> `bypass`=00.
- Flush: `do_flush` with load-use hazard in S2 -> `fe_stall` 0, next `s3_valid` 0.
- Freeze: `ext_stall` 3 cycles mid load-use -> outputs held, stall resumes, total hazard bubbles still 2.
- Reset low during stall -> `s3_valid` 0, `bypass` 00, counters 0 asynchronously.
